// File: rtl/tetris_cmd_scheduler_pkg.sv
// Shared definitions for the Tetris command scheduler: command codes,
// arbiter FSM state encoding and a saturating level helper.
package tetris_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE  = 3'b000;
    localparam cmd_t CMD_DOWN  = 3'b100;
    localparam cmd_t CMD_LEFT  = 3'b101;
    localparam cmd_t CMD_RIGHT = 3'b110;
    localparam cmd_t CMD_ROT   = 3'b111;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;
    localparam logic [1:0] ST_PAUSED = 2'd3;

    localparam logic [3:0] LEVEL_MAX = 4'd15;

    function automatic logic [3:0] level_add(input logic [3:0] lvl, input logic [2:0] inc);
        logic [4:0] sum;
        sum = {1'b0, lvl} + {2'b00, inc};
        return (sum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : sum[3:0];
    endfunction

endpackage

// File: rtl/tetris_cmd_scheduler_if.sv
// Command stream between the scheduler (master) and game control (slave).
interface tetris_cmd_scheduler_if;
    import tetris_pkg::*;

    logic cmd_valid;
    logic cmd_ready;
    cmd_t cmd_code;

    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);

endinterface

// File: rtl/tetris_cmd_scheduler_key_repeat.sv
// Key edge detection plus DAS/ARR auto-repeat timer; emits a one-cycle
// event with the key code on each new press and on every repeat.
module tetris_key_repeat
    import tetris_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int DAS_DELAY  = 17_000_000,
    parameter int ARR_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  cmd_t key_code,
    output logic key_event,
    output cmd_t key_event_code
);

    localparam logic [CNT_W-1:0] DAS_M1 = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_M1 = CNT_W'(ARR_PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    cmd_t             prev_code_r;
    logic [CNT_W-1:0] rep_cnt_r;
    logic             das_done_r;

    logic             new_s;
    logic             held_s;
    logic             rep_hit_s;
    logic [CNT_W-1:0] rep_limit_s;

    // classify the current key relative to the previously sampled one
    always_comb begin
        new_s       = (key_code != CMD_NONE) && (key_code != prev_code_r);
        held_s      = (key_code != CMD_NONE) && (key_code == prev_code_r) && (key_code != CMD_ROT);
        rep_limit_s = das_done_r ? ARR_M1 : DAS_M1;
        rep_hit_s   = held_s && (rep_cnt_r == rep_limit_s);
    end

    // previous-code sampler and repeat timer; frozen while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_code_r <= CMD_NONE;
            rep_cnt_r   <= '0;
            das_done_r  <= 1'b0;
        end else if (en) begin
            prev_code_r <= key_code;
            if (!held_s) begin
                // new press, release or rotate: restart from the DAS phase
                rep_cnt_r  <= '0;
                das_done_r <= 1'b0;
            end else if (rep_hit_s) begin
                rep_cnt_r  <= '0;
                das_done_r <= 1'b1;
            end else begin
                rep_cnt_r  <= rep_cnt_r + ONE_C;
            end
        end
    end

    assign key_event      = en && (new_s || rep_hit_s);
    assign key_event_code = key_code;

endmodule

// File: rtl/tetris_cmd_scheduler.sv
// Merges key commands and gravity ticks into one valid/ready command stream
// and owns level/fall speed. Optional pause input under `define PAUSE_EN.
module tetris_cmd_scheduler
    import tetris_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int BASE_PERIOD   = 50_000_000,
    parameter int STEP          = 3_000_000,
    parameter int MIN_PERIOD    = 5_000_000,
    parameter int DAS_DELAY     = 17_000_000,
    parameter int ARR_PERIOD    = 5_000_000,
    parameter int LINES_PER_LVL = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    key_code,
    input  logic                          fail,
    input  logic [2:0]                    lines_cleared,
`ifdef PAUSE_EN
    input  logic                          pause_key,
`endif
    tetris_cmd_scheduler_if.master        cmd,
    output logic [3:0]                    level,
    output logic                          halted
);

    localparam int ACC_W = 8;
    localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [ACC_W-1:0] LPL_C  = ACC_W'(LINES_PER_LVL);

    logic [1:0]       state_r, state_n;
    logic             cmd_valid_r, cmd_valid_n;
    cmd_t             cmd_code_r, cmd_code_n;
    cmd_t             key_pend_r, key_pend_n;
    logic             grav_pend_r, grav_pend_n;
    logic             halted_r;
    logic [3:0]       level_r;
    logic [ACC_W-1:0] line_acc_r;
    logic [CNT_W-1:0] grav_cnt_r;

    logic             run_s;
    logic             xfer_s;
    logic             accept_down_s;
    logic             grav_tick_s;
    logic [CNT_W-1:0] period_cut_s;
    logic [CNT_W-1:0] period_s;
    logic [ACC_W-1:0] acc_work_s;
    logic [2:0]       lvl_inc_s;
    logic             key_event_s;
    cmd_t             key_event_code_s;

`ifdef PAUSE_EN
    logic             pause_prev_r;
    logic             pause_rise_s;

    // pause button edge detector, runs in every state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause_prev_r <= 1'b0;
        end else begin
            pause_prev_r <= pause_key;
        end
    end

    assign pause_rise_s = pause_key && !pause_prev_r;
`endif

    tetris_key_repeat #(
        .CNT_W      (CNT_W),
        .DAS_DELAY  (DAS_DELAY),
        .ARR_PERIOD (ARR_PERIOD)
    ) u_key_repeat (
        .clk            (clk),
        .rst            (rst),
        .en             (run_s),
        .key_code       (key_code),
        .key_event      (key_event_s),
        .key_event_code (key_event_code_s)
    );

    // gravity period from level, clamped at the floor without underflow
    always_comb begin
        run_s         = ((state_r == ST_IDLE) || (state_r == ST_ISSUE)) && !fail;
        xfer_s        = cmd_valid_r && cmd.cmd_ready;
        accept_down_s = xfer_s && (cmd_code_r == CMD_DOWN);
        period_cut_s  = CNT_W'(level_r) * STEP_C;
        if (period_cut_s >= (BASE_C - MIN_C)) begin
            period_s = MIN_C;
        end else begin
            period_s = BASE_C - period_cut_s;
        end
        grav_tick_s = run_s && (grav_cnt_r >= (period_s - ONE_C));
    end

    // line accumulator: a burst of lines may cross several level boundaries
    always_comb begin
        acc_work_s = line_acc_r + ACC_W'(lines_cleared);
        lvl_inc_s  = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (acc_work_s >= LPL_C) begin
                acc_work_s = acc_work_s - LPL_C;
                lvl_inc_s  = lvl_inc_s + 3'd1;
            end else begin
                acc_work_s = acc_work_s;
            end
        end
    end

    // arbiter: key pend beats gravity pend; output reg only reloads when free
    always_comb begin
        state_n     = state_r;
        cmd_valid_n = cmd_valid_r;
        cmd_code_n  = cmd_code_r;
        key_pend_n  = key_pend_r;
        grav_pend_n = grav_pend_r;
        case (state_r)
            ST_IDLE, ST_ISSUE: begin
                if (!cmd_valid_r || xfer_s) begin
                    if (key_pend_r != CMD_NONE) begin
                        state_n     = ST_ISSUE;
                        cmd_valid_n = 1'b1;
                        cmd_code_n  = key_pend_r;
                        key_pend_n  = CMD_NONE;
                    end else if (grav_pend_r && !accept_down_s) begin
                        state_n     = ST_ISSUE;
                        cmd_valid_n = 1'b1;
                        cmd_code_n  = CMD_DOWN;
                        grav_pend_n = 1'b0;
                    end else begin
                        state_n     = ST_IDLE;
                        cmd_valid_n = 1'b0;
                        cmd_code_n  = CMD_NONE;
                    end
                end else begin
                    state_n = ST_ISSUE;
                end
            end
`ifdef PAUSE_EN
            ST_PAUSED: begin
                if (pause_rise_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_PAUSED;
                end
            end
`endif
            ST_HALT: state_n = ST_HALT;
            default: state_n = ST_IDLE;
        endcase

        // a move down already accepted makes any pending tick redundant
        if (accept_down_s) begin
            grav_pend_n = 1'b0;
        end else if (grav_tick_s) begin
            grav_pend_n = 1'b1;
        end else begin
            grav_pend_n = grav_pend_n;
        end

        if (key_event_s) begin
            key_pend_n = key_event_code_s;
        end else begin
            key_pend_n = key_pend_n;
        end

`ifdef PAUSE_EN
        if (pause_rise_s && ((state_r == ST_IDLE) || (state_r == ST_ISSUE))) begin
            // hand the presented command back to the pends so it re-issues on resume
            if (cmd_valid_n && (cmd_code_n == CMD_DOWN)) begin
                grav_pend_n = 1'b1;
            end else if (cmd_valid_n && (key_pend_n == CMD_NONE)) begin
                key_pend_n = cmd_code_n;
            end else begin
                key_pend_n = key_pend_n;
            end
            state_n     = ST_PAUSED;
            cmd_valid_n = 1'b0;
            cmd_code_n  = CMD_NONE;
        end else begin
            state_n = state_n;
        end
`endif

        if (fail) begin
            state_n     = ST_HALT;
            cmd_valid_n = 1'b0;
            cmd_code_n  = CMD_NONE;
            key_pend_n  = CMD_NONE;
            grav_pend_n = 1'b0;
        end else begin
            state_n = state_n;
        end
    end

    // FSM, pend flags and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= CMD_NONE;
            key_pend_r  <= CMD_NONE;
            grav_pend_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            cmd_valid_r <= cmd_valid_n;
            cmd_code_r  <= cmd_code_n;
            key_pend_r  <= key_pend_n;
            grav_pend_r <= grav_pend_n;
            halted_r    <= (state_n == ST_HALT);
        end
    end

    // gravity counter and level; both frozen outside IDLE/ISSUE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grav_cnt_r <= '0;
            line_acc_r <= '0;
            level_r    <= 4'd0;
        end else if (run_s) begin
            if (accept_down_s || grav_tick_s) begin
                grav_cnt_r <= '0;
            end else begin
                grav_cnt_r <= grav_cnt_r + ONE_C;
            end
            line_acc_r <= acc_work_s;
            level_r    <= level_add(level_r, lvl_inc_s);
        end
    end

    assign cmd.cmd_valid = cmd_valid_r;
    assign cmd.cmd_code  = cmd_code_r;
    assign level         = level_r;
    assign halted        = halted_r;

endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Randomised bench for tetris_cmd_scheduler with an in-bench behavioural
// model compared every cycle, plus directed scenarios with literal pins.
module tb_tetris_cmd_scheduler;
    import tetris_pkg::*;

    localparam int BASE = 20;
    localparam int STP  = 4;
    localparam int MINP = 6;
    localparam int DAS  = 10;
    localparam int ARR  = 3;
    localparam int LPL  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] key_code = 3'd0;
    logic       fail = 1'b0;
    logic [2:0] lines_cleared = 3'd0;
    logic       pause_key = 1'b0;
    logic [3:0] level;
    logic       halted;

    tetris_cmd_scheduler_if cmd_if ();

    always #5 clk = ~clk;

    tetris_cmd_scheduler #(
        .CNT_W(32), .BASE_PERIOD(BASE), .STEP(STP), .MIN_PERIOD(MINP),
        .DAS_DELAY(DAS), .ARR_PERIOD(ARR), .LINES_PER_LVL(LPL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_code      (key_code),
        .fail          (fail),
        .lines_cleared (lines_cleared),
`ifdef PAUSE_EN
        .pause_key     (pause_key),
`endif
        .cmd           (cmd_if),
        .level         (level),
        .halted        (halted)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_prev, m_len, m_kp, m_gp, m_gcnt, m_total, m_valid, m_code, m_halt;

    // transfers observed on the DUT bus, used for directed pins
    int xfer_cnt [8];
    int xfer_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_level();
        int l;
        l = m_total / LPL;
        return (l > 15) ? 15 : l;
    endfunction

    function automatic int m_period();
        int p;
        p = BASE - m_level() * STP;
        return (p < MINP) ? MINP : p;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_len = 0; m_kp = 0; m_gp = 0; m_gcnt = 0;
        m_total = 0; m_valid = 0; m_code = 0; m_halt = 0;
    endtask

    // advance the model by one clock edge using the inputs presented now
    task automatic model_step();
        bit ev, xfer, acc_down, tick;
        int kc;
        kc = int'(key_code);
        if (m_halt != 0) return;
        if (fail) begin
            m_halt = 1; m_valid = 0; m_code = 0; m_kp = 0; m_gp = 0;
            return;
        end
        ev = 1'b0;
        if (kc != 0 && kc != m_prev) begin
            ev = 1'b1;
            m_len = 0;
        end else if (kc != 0) begin
            m_len++;
            if (kc != 7 && m_len >= DAS && ((m_len - DAS) % ARR) == 0) ev = 1'b1;
        end else begin
            m_len = 0;
        end
        m_prev = kc;

        xfer     = (m_valid != 0) && cmd_if.cmd_ready;
        acc_down = xfer && (m_code == 4);
        tick     = (m_gcnt >= m_period() - 1);
        m_gcnt   = (acc_down || tick) ? 0 : m_gcnt + 1;

        if (m_valid == 0 || xfer) begin
            if (m_kp != 0) begin
                m_code = m_kp; m_kp = 0; m_valid = 1;
            end else if (m_gp != 0 && !acc_down) begin
                m_code = 4; m_gp = 0; m_valid = 1;
            end else begin
                m_code = 0; m_valid = 0;
            end
        end
        if (acc_down) m_gp = 0;
        else if (tick) m_gp = 1;
        if (ev) m_kp = kc;
        m_total += int'(lines_cleared);
    endtask

    task automatic compare_all();
        check("cmd_valid", 32'(cmd_if.cmd_valid), 32'(m_valid));
        check("cmd_code",  32'(cmd_if.cmd_code),  32'(m_code));
        check("level",     32'(level),            32'(m_level()));
        check("halted",    32'(halted),           32'(m_halt));
    endtask

    // one clock: log any transfer, step model, then compare just after the edge
    task automatic tick();
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            xfer_cnt[cmd_if.cmd_code]++;
            xfer_q.push_back(int'(cmd_if.cmd_code));
        end
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        for (int i = 0; i < 8; i++) xfer_cnt[i] = 0;
        xfer_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        check("rst_cmd_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("rst_cmd_code",  32'(cmd_if.cmd_code),  32'd0);
        check("rst_level",     32'(level),            32'd0);
        check("rst_halted",    32'(halted),           32'd0);
        model_reset();
        clear_log();
        key_code = 3'd0; fail = 1'b0; lines_cleared = 3'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] key_tab [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

    initial begin
        int first;
        cmd_if.cmd_ready = 1'b1;

        // gravity only: first down appears 21 edges after reset
        do_reset();
        first = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (cmd_if.cmd_valid && first < 0) first = n;
        end
        check("first_gravity_edge", 32'(first), 32'd21);
        ticks(40);
        check("gravity_only_down", 32'(xfer_cnt[4] > 0), 32'd1);

        // left held 20 cycles: press + 4 repeats, then coincident gravity after key
        do_reset();
        key_code = 3'd5;
        first = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (cmd_if.cmd_valid && first < 0) first = n;
        end
        key_code = 3'd0;
        ticks(15);
        check("left_latency", 32'(first), 32'd2);
        check("left_count", 32'(xfer_cnt[5]), 32'd5);
        check("down_count", 32'(xfer_cnt[4]), 32'd1);
        check("b2b_size", 32'(xfer_q.size()), 32'd6);
        if (xfer_q.size() == 6) begin
            check("b2b_key_first", 32'(xfer_q[4]), 32'd5);
            check("b2b_then_down", 32'(xfer_q[5]), 32'd4);
        end

        // rotate never repeats
        do_reset();
        key_code = 3'd7;
        ticks(20);
        key_code = 3'd0;
        ticks(10);
        check("rotate_count", 32'(xfer_cnt[7]), 32'd1);

        // stalled consumer: held command stays, newest key issues next
        do_reset();
        cmd_if.cmd_ready = 1'b0;
        key_code = 3'd5;
        ticks(5);
        key_code = 3'd6;
        ticks(5);
        key_code = 3'd0;
        ticks(40);
        check("stall_code", 32'(cmd_if.cmd_code), 32'd5);
        check("stall_valid", 32'(cmd_if.cmd_valid), 32'd1);
        cmd_if.cmd_ready = 1'b1;
        ticks(5);
        check("stall_xfers", 32'(xfer_q.size() >= 3), 32'd1);
        if (xfer_q.size() >= 3) begin
            check("stall_xfer0", 32'(xfer_q[0]), 32'd5);
            check("stall_xfer1", 32'(xfer_q[1]), 32'd6);
            check("stall_xfer2", 32'(xfer_q[2]), 32'd4);
        end

        // level from cleared lines, saturation and period floor
        do_reset();
        lines_cleared = 3'd4;
        tick();
        lines_cleared = 3'd0;
        check("level_after_4", 32'(level), 32'd2);
        lines_cleared = 3'd4;
        ticks(4);
        lines_cleared = 3'd0;
        tick();
        check("level_after_20", 32'(level), 32'd10);
        lines_cleared = 3'd4;
        ticks(5);
        lines_cleared = 3'd0;
        tick();
        check("level_saturated", 32'(level), 32'd15);
        ticks(40);

        // fail while a command is presented halts everything
        do_reset();
        cmd_if.cmd_ready = 1'b0;
        key_code = 3'd7;
        tick();
        key_code = 3'd0;
        tick();
        check("issue_before_fail", 32'(cmd_if.cmd_valid), 32'd1);
        fail = 1'b1;
        tick();
        fail = 1'b0;
        check("fail_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("fail_halted", 32'(halted), 32'd1);
        clear_log();
        cmd_if.cmd_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            key_code = key_tab[$urandom_range(4, 0)];
            tick();
        end
        check("halt_no_xfers", 32'(xfer_q.size()), 32'd0);

        // randomised episodes against the model
        for (int ep = 0; ep < 6; ep++) begin
            int hold;
            int fail_at;
            do_reset();
            hold = 0;
            fail_at = (ep % 2 == 1) ? 300 + int'($urandom_range(150, 0)) : -1;
            for (int n = 0; n < 500; n++) begin
                if (hold == 0) begin
                    key_code = key_tab[$urandom_range(4, 0)];
                    hold = int'($urandom_range(25, 1));
                end
                hold--;
                cmd_if.cmd_ready = (ep == 2) ? ($urandom_range(9, 0) == 0)
                                             : ($urandom_range(3, 0) != 0);
                lines_cleared = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(4, 0)) : 3'd0;
                fail = (n == fail_at);
                tick();
            end
            fail = 1'b0;
        end

        do_reset();
        ticks(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
